// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave.
//   state_t          : frame FSM encoding (IDLE / SHIFT / DONE)
//   TURNAROUND_BITS  : command bits received before a 3-wire slave turns the data line around
//   MAX_BITS         : widest supported frame
package spi_pkg;

    localparam int TURNAROUND_BITS = 8;
    localparam int MAX_BITS        = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/spi_sync.sv
// Synchronizer plus edge detector for one asynchronous SPI input.
// Ports:
//   clk_in : system clock
//   rst    : asynchronous active-high reset (chain and edge flop reset to 1,
//            matching the idle level of every SPI line, so no edge appears out of reset)
//   d      : raw asynchronous input
//   q      : synchronized level
//   rise   : one-cycle pulse on a synchronized 0->1 transition
//   fall   : one-cycle pulse on a synchronized 1->0 transition
// SYNC_STAGES must be at least 2.
module spi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q[SYNC_STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave, SCL idles high, data driven on SCL falling edges and sampled on
// rising edges, MSB first, frame length nbits+1 (1..32) latched at frame start.
// Ports:
//   clk_in, rst         : system clock, asynchronous active-high reset
//   nbits               : frame length minus one
//   tx_data, tx_load    : response word and its load strobe (honoured only when idle)
//   rx_data, rx_valid   : last complete frame (right-aligned) and its update pulse
//   busy, frame_err     : frame in progress, and pulse on chip enable lost mid-frame
//   spi_cen/scl/sdi/sdo : SPI pins
// Build option SPI3WIRE_EN: adds input spi3w and makes spi_sdi bidirectional.
// With spi3w=1 the first TURNAROUND_BITS bits are a command received on spi_sdi,
// after which the slave drives its response on spi_sdi (mirroring spi_sdo).
module spi_slave
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [4:0]  nbits,
    input  logic [31:0] tx_data,
    input  logic        tx_load,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        busy,
    output logic        frame_err,
    input  logic        spi_cen,
    input  logic        spi_scl,
`ifdef SPI3WIRE_EN
    input  logic        spi3w,
    inout  wire         spi_sdi,
`else
    input  logic        spi_sdi,
`endif
    output logic        spi_sdo
);

    localparam logic [4:0] TURN = 5'(TURNAROUND_BITS);

    state_t                state_q, state_d;
    logic [4:0]            len_q, len_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [MAX_BITS-2:0]   shift_q, shift_d;
    logic [MAX_BITS-1:0]   tx_reg_q, tx_reg_d;
    logic [MAX_BITS-1:0]   rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  busy_q, busy_d;
    logic                  sdo_q, sdo_d;
    logic                  oe_q, oe_d;

    logic cen_s, cen_fall, cen_rise_unused;
    logic scl_rise, scl_fall, scl_s_unused;
    logic sdi_s, sdi_rise_unused, sdi_fall_unused;
    logic mode3w;
    logic past_turn;
    logic [4:0] bits_done;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cen (
        .clk_in(clk_in), .rst(rst), .d(spi_cen),
        .q(cen_s), .rise(cen_rise_unused), .fall(cen_fall)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_scl (
        .clk_in(clk_in), .rst(rst), .d(spi_scl),
        .q(scl_s_unused), .rise(scl_rise), .fall(scl_fall)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk_in(clk_in), .rst(rst), .d(spi_sdi),
        .q(sdi_s), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
    );

`ifdef SPI3WIRE_EN
    assign mode3w  = spi3w;
    // Slave owns the shared data line only after the command phase.
    assign spi_sdi = oe_q ? sdo_q : 1'bz;
`else
    logic oe_unused;
    assign mode3w    = 1'b0;
    assign oe_unused = oe_q;
`endif

    // bit_cnt counts down from len, so len - bit_cnt is the number of bits already
    // clocked in; it never underflows.
    assign bits_done = len_q - bit_cnt_q;
    assign past_turn = mode3w && (bits_done >= TURN);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_reg_d    = tx_reg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        sdo_d       = sdo_q;
        oe_d        = oe_q;

        case (state_q)
            ST_IDLE: begin
                sdo_d = 1'b1;
                oe_d  = 1'b0;
                if (tx_load) tx_reg_d = tx_data;
                if (cen_fall) begin
                    state_d   = ST_SHIFT;
                    len_d     = nbits;
                    bit_cnt_d = nbits;
                    shift_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (cen_s) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                    sdo_d       = 1'b1;
                    oe_d        = 1'b0;
                end else if (scl_fall) begin
                    sdo_d = tx_reg_q[bit_cnt_q];
                    if (past_turn) oe_d = 1'b1;
                end else if (scl_rise) begin
                    // In 3-wire mode the data line carries our own response after
                    // the command, so stop shifting and keep the command right-aligned.
                    if (!past_turn) shift_d = {shift_q[MAX_BITS-3:0], sdi_s};
                    if (bit_cnt_q == 5'd0) begin
                        state_d    = ST_DONE;
                        rx_data_d  = past_turn ? {1'b0, shift_q} : {shift_q, sdi_s};
                        rx_valid_d = 1'b1;
                        sdo_d      = 1'b1;
                        oe_d       = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 5'd1;
                    end
                end
            end
            ST_DONE: begin
                sdo_d = 1'b1;
                oe_d  = 1'b0;
                if (cen_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_reg_q    <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            sdo_q       <= 1'b1;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_reg_q    <= tx_reg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
            sdo_q       <= sdo_d;
            oe_q        <= oe_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
    assign spi_sdo   = sdo_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed frame table, reset-mid-frame sequence, random
// frames against a word-level model, plus a 3-wire sequence when SPI3WIRE_EN is set.
module tb_spi_slave;

    localparam int H = 6;  // SCL half period in clk_in cycles

    logic        clk_in = 1'b0;
    logic        rst;
    logic [4:0]  nbits;
    logic [31:0] tx_data;
    logic        tx_load;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        busy;
    logic        frame_err;
    logic        spi_cen;
    logic        spi_scl;
    logic        sdi_drv;
    logic        spi_sdo;
    wire         spi_sdi_w;

    int n_checks = 0;
    int n_errors = 0;
    int valid_cnt = 0;
    int err_cnt = 0;

    logic [31:0] tx_word = 32'h0;
    logic [31:0] rx_word = 32'h0;

`ifdef SPI3WIRE_EN
    logic spi3w;
    logic sdi_oe;
    assign spi_sdi_w = sdi_oe ? sdi_drv : 1'bz;
`else
    assign spi_sdi_w = sdi_drv;
`endif

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk_in(clk_in), .rst(rst), .nbits(nbits), .tx_data(tx_data), .tx_load(tx_load),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .frame_err(frame_err),
        .spi_cen(spi_cen), .spi_scl(spi_scl),
`ifdef SPI3WIRE_EN
        .spi3w(spi3w),
`endif
        .spi_sdi(spi_sdi_w), .spi_sdo(spi_sdo)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (rx_valid === 1'b1) valid_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

    typedef struct {
        logic [4:0]  nb;
        logic [31:0] tx;
        int          load_mode;   // 0 none, 1 before frame, 2 same cycle as cen fall
        logic [31:0] mosi;
        int          abort_at;    // 0 = full frame, else bits sent before cen rises
        int          busy_ld;     // pulse tx_load (with tx) mid-frame
        logic [31:0] exp_rx;
        logic [31:0] exp_miso;
        int          exp_valid;
        int          exp_err;
    } vec_t;

    function automatic logic [31:0] mask_n(int n);
        logic [63:0] m;
        m = (64'd1 << n) - 64'd1;
        return m[31:0];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic frame(input vec_t v, output logic [31:0] miso);
        int nsend;
        nsend = (v.abort_at > 0) ? v.abort_at : int'(v.nb) + 1;
        @(negedge clk_in);
        nbits   = v.nb;
        tx_data = v.tx;
        if (v.load_mode == 1) begin
            tx_load = 1'b1;
            @(negedge clk_in);
            tx_load = 1'b0;
        end
        spi_cen = 1'b0;
        if (v.load_mode == 2) tx_load = 1'b1;
        @(negedge clk_in);
        tx_load = 1'b0;
        wait_cyc(H - 1);
        nbits = ~v.nb;  // must not affect a frame already started
        miso = '0;
        for (int i = 0; i < nsend; i++) begin
            spi_scl = 1'b0;
            sdi_drv = v.mosi[int'(v.nb) - i];
            if (i == 0) begin
                @(negedge clk_in);
                chk("busy_mid", {31'b0, busy}, 32'd1);
                wait_cyc(H - 1);
            end else if (i == 1 && v.busy_ld != 0) begin
                tx_data = v.tx;
                tx_load = 1'b1;
                @(negedge clk_in);
                tx_load = 1'b0;
                wait_cyc(H - 1);
            end else begin
                wait_cyc(H);
            end
            miso = {miso[30:0], spi_sdo};
            spi_scl = 1'b1;
            wait_cyc(H);
        end
        spi_cen = 1'b1;
        sdi_drv = 1'b1;
        wait_cyc(2 * H);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [31:0] miso;
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        frame(v, miso);
        chk({tag, "_rx"}, rx_data, v.exp_rx);
        chk({tag, "_miso"}, miso, v.exp_miso);
        chk({tag, "_nvalid"}, 32'(valid_cnt - v0), 32'(v.exp_valid));
        chk({tag, "_nerr"}, 32'(err_cnt - e0), 32'(v.exp_err));
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_sdo"}, {31'b0, spi_sdo}, 32'd1);
        if (v.load_mode != 0) tx_word = v.tx;
        if (v.abort_at == 0) rx_word = v.mosi & mask_n(int'(v.nb) + 1);
    endtask

`ifdef SPI3WIRE_EN
    task automatic three_wire();
        logic [7:0]  cmd;
        logic [31:0] resp;
        cmd = 8'h81;
        resp = '0;
        @(negedge clk_in);
        nbits = 5'd15; tx_data = 32'h0000_00C7; tx_load = 1'b1;
        @(negedge clk_in);
        tx_load = 1'b0; spi3w = 1'b1; spi_cen = 1'b0;
        wait_cyc(H);
        for (int i = 0; i < 16; i++) begin
            spi_scl = 1'b0;
            if (i < 8) begin sdi_oe = 1'b1; sdi_drv = cmd[7 - i]; end
            else sdi_oe = 1'b0;
            wait_cyc(H);
            if (i >= 8) resp = {resp[30:0], spi_sdi_w};
            spi_scl = 1'b1;
            wait_cyc(H);
        end
        spi_cen = 1'b1; sdi_oe = 1'b1; sdi_drv = 1'b1;
        wait_cyc(2 * H);
        chk("3w_resp", resp, 32'h0000_00C7);
        chk("3w_rx", rx_data, 32'h0000_0081);
        spi3w = 1'b0;
        tx_word = 32'h0000_00C7;
        rx_word = 32'h0000_0081;
    endtask
`endif

    vec_t tbl[8];

    initial begin
        vec_t v;
        logic [31:0] t;
        int nsend;

        tbl[0] = '{5'd15, 32'h0000_A5C3, 1, 32'h0000_1234, 0, 0, 32'h0000_1234, 32'h0000_A5C3, 1, 0};
        tbl[1] = '{5'd31, 32'hDEAD_BEEF, 1, 32'h0102_0304, 0, 0, 32'h0102_0304, 32'hDEAD_BEEF, 1, 0};
        tbl[2] = '{5'd15, 32'h0,         0, 32'h0000_FFFF, 5, 0, 32'h0102_0304, 32'h0000_0017, 0, 1};
        tbl[3] = '{5'd7,  32'h0000_003C, 1, 32'h0000_00A7, 0, 0, 32'h0000_00A7, 32'h0000_003C, 1, 0};
        tbl[4] = '{5'd7,  32'h0000_0055, 0, 32'h0000_0011, 0, 1, 32'h0000_0011, 32'h0000_003C, 1, 0};
        tbl[5] = '{5'd7,  32'h0,         0, 32'h0000_00E2, 0, 0, 32'h0000_00E2, 32'h0000_003C, 1, 0};
        tbl[6] = '{5'd7,  32'h0000_0096, 2, 32'h0000_0000, 0, 0, 32'h0000_0000, 32'h0000_0096, 1, 0};
        tbl[7] = '{5'd0,  32'h0000_0001, 1, 32'h0000_0001, 0, 0, 32'h0000_0001, 32'h0000_0001, 1, 0};

        rst = 1'b1; nbits = '0; tx_data = '0; tx_load = 1'b0;
        spi_cen = 1'b1; spi_scl = 1'b1; sdi_drv = 1'b1;
`ifdef SPI3WIRE_EN
        spi3w = 1'b0; sdi_oe = 1'b1;
`endif
        wait_cyc(5);
        rst = 1'b0;
        wait_cyc(5);
        chk("rst_rx_data", rx_data, 32'h0);
        chk("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_frame_err", {31'b0, frame_err}, 32'd0);
        chk("rst_sdo", {31'b0, spi_sdo}, 32'd1);

        for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // reset asserted during bit 7 of an 8-bit frame
        @(negedge clk_in);
        nbits = 5'd7; spi_cen = 1'b0;
        wait_cyc(H);
        for (int i = 0; i < 6; i++) begin
            spi_scl = 1'b0; sdi_drv = i[0]; wait_cyc(H);
            spi_scl = 1'b1; wait_cyc(H);
        end
        spi_scl = 1'b0;
        wait_cyc(H);
        rst = 1'b1;
        @(negedge clk_in);
        chk("rstmid_sdo", {31'b0, spi_sdo}, 32'd1);
        chk("rstmid_busy", {31'b0, busy}, 32'd0);
        chk("rstmid_rx", rx_data, 32'h0);
        spi_cen = 1'b1; spi_scl = 1'b1; sdi_drv = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(H);
        chk("rstmid_idle", {31'b0, busy}, 32'd0);
        tx_word = '0;
        rx_word = '0;
        v = '{5'd7, 32'h0, 0, 32'h0000_005A, 0, 0, 32'h0000_005A, 32'h0, 1, 0};
        run_vec(v, "post_rst");

`ifdef SPI3WIRE_EN
        three_wire();
`endif

        for (int k = 0; k < 20; k++) begin
            v.nb        = 5'($urandom_range(0, 31));
            v.tx        = $urandom;
            v.load_mode = int'($urandom_range(0, 2));
            v.mosi      = $urandom;
            v.busy_ld   = int'($urandom_range(0, 1));
            v.abort_at  = (v.nb > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, v.nb)) : 0;
            nsend = (v.abort_at > 0) ? v.abort_at : int'(v.nb) + 1;
            t = (v.load_mode != 0) ? v.tx : tx_word;
            t = t & mask_n(int'(v.nb) + 1);
            v.exp_miso  = t >> (int'(v.nb) + 1 - nsend);
            v.exp_rx    = (v.abort_at > 0) ? rx_word : (v.mosi & mask_n(int'(v.nb) + 1));
            v.exp_valid = (v.abort_at > 0) ? 0 : 1;
            v.exp_err   = (v.abort_at > 0) ? 1 : 0;
            run_vec(v, $sformatf("rnd%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of clk_in synchronizer flops on spi_cen, spi_scl and spi_sdi (minimum 2).
REQ-002 SHALL have port clk_in, input, 1 bit: the single system clock.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port nbits, input, 5 bits: frame length minus 1 (0..31), sampled at frame start.
REQ-005 SHALL have port tx_data, input, 32 bits: response word; bits [nbits:0] are sent MSB first.
REQ-006 SHALL have port tx_load, input, 1 bit: copies tx_data into tx_reg when asserted in IDLE; ignored otherwise.
REQ-007 SHALL have port rx_data, output, 32 bits: last received frame, right-aligned, with bits above nbits zero.
REQ-008 SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rx_data updates.
REQ-009 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse when spi_cen deasserts mid-frame.
REQ-011 SHALL have port spi_cen, input, 1 bit: active-low chip enable from the master.
REQ-012 SHALL have port spi_scl, input, 1 bit: serial clock from the master; idles high.
REQ-013 SHALL have port spi_sdi, input, 1 bit: master-to-slave data (inout under SPI3WIRE_EN).
REQ-014 SHALL have port spi_sdo, output, 1 bit: slave-to-master data.

Function
REQ-015 SHALL pass spi_cen, spi_scl and spi_sdi through SYNC_STAGES flops, then detect edges with one additional flop.
- SCL rise/fall pulses are one clk_in cycle long.
REQ-016 SHALL operate correctly for SCL high and low phases of at least SYNC_STAGES+2 clk_in cycles.
REQ-017 SHALL implement states IDLE, SHIFT and DONE.
- IDLE->SHIFT on synced spi_cen falling; at that point latch nbits into len_reg, set bit_cnt=len_reg, and clear the shift register.
- SHIFT: on each SCL falling edge drive spi_sdo=tx_reg[bit_cnt].
- SHIFT: on each SCL rising edge shift in the synced spi_sdi and decrement bit_cnt.
- SHIFT->DONE on the rising edge where bit_cnt==0; in the same cycle update rx_data and pulse rx_valid.
- DONE->IDLE on spi_cen high; in DONE, further SCL edges are ignored and spi_sdo holds 1.
- SHIFT->IDLE on spi_cen high before the last bit; pulse frame_err, keep rx_data unchanged, no rx_valid.
REQ-018 SHALL drive spi_sdo=1 in IDLE and DONE.
REQ-019 SHALL make sampling coincide with master capture: data is driven on SCL falling edges and sampled on SCL rising edges.
REQ-020 SHALL retain tx_reg across frames.
- A frame with no preceding tx_load retransmits the previous word.
- A tx_load in the same cycle as the spi_cen fall is accepted.
REQ-021 SHALL ignore SCL edges while spi_cen is high.
REQ-022 SHALL use rx_valid latency of 1 clk_in cycle after the synced last SCL rising edge.

Reset
REQ-023 SHALL, on rst high, asynchronously set:
- state=IDLE
- tx_reg=0, rx_data=0
- rx_valid=0, frame_err=0, busy=0
- spi_sdo=1
- synchronizer flops=1
- 3-wire output enable=0
REQ-024 SHALL, on reset mid-frame, abandon the frame; after release it waits for the next spi_cen fall.

Configuration
REQ-025 SHALL support macro SPI3WIRE_EN.
- With SPI3WIRE_EN: add input spi3w, and spi_sdi becomes inout.
- With SPI3WIRE_EN and spi3w=1: release spi_sdi for the first 8 bits; from the 9th SCL falling edge (bit_cnt==len_reg-8) drive spi_sdi with the same bit as spi_sdo until spi_cen rises or the frame ends.
- With SPI3WIRE_EN and spi3w=1: rx_data captures only the first 8 bits received.
- Without SPI3WIRE_EN: spi_sdi is input only and behaviour is 4-wire only.

Structure
REQ-026 SHALL place state encodings, TURNAROUND_BITS=8 and MAX_BITS=32 in shared package spi_pkg.
REQ-027 SHALL instantiate one sub-module, spi_sync, containing the synchronizer and rise/fall detector; it is instantiated once per SPI input.

Verification
REQ-028 SHALL cover a 16-bit frame: nbits=15, tx_load with tx_data=0x0000A5C3, master sends 0x1234 -> rx_data=0x00001234, rx_valid one pulse, master reads 0xA5C3.
REQ-029 SHALL cover a 32-bit frame: nbits=31, tx_data=0xDEADBEEF, master sends 0x01020304 -> rx_data=0x01020304, master reads 0xDEADBEEF.
REQ-030 SHALL cover an aborted frame: spi_cen rises after 5 of 16 bits -> frame_err pulse, no rx_valid, rx_data unchanged, busy=0.
REQ-031 SHALL cover reset mid-frame: rst asserted at bit 7 -> spi_sdo=1, busy=0; a following 8-bit frame sending 0x5A gives rx_data=0x5A.
REQ-032 SHALL cover retransmission: two 8-bit frames with one tx_load of 0x3C -> master reads 0x3C both times; tx_load while busy is ignored.
REQ-033 SHALL cover 3-wire mode (SPI3WIRE_EN, spi3w=1): nbits=15, command 0x81, tx_data=0x00C7 -> slave drives 0xC7 on bits 9-16, rx_data=0x81.
